// File: rtl/conv_top_module.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : conv_top_module (with helper conv_fifo)                       |
// | Purpose  : 1-D unsigned convolution engine. Filter and IF words arrive   |
// |            through FIFOs, are staged into small scratchpads, then one    |
// |            MAC per cycle produces each strided output. Each output goes  |
// |            to a first-word-fall-through result FIFO.                     |
// | Ports    : clk, rst (sync, active-high), chip_en (global hold), start,   |
// |            filter_size/if_size/stride (job shape), filter/if buffer      |
// |            write data + enables, read_buffer_result (pop result),        |
// |            Done (job complete), par_sum (result FIFO head or 0).         |
// | Options  : CONV_RESULT_SATURATE_EN - accumulator saturates at all-ones   |
// |            instead of wrapping.                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

// Synchronous FIFO, first-word fall-through. A pop removes up to POP_N
// entries. A push is accepted when not full, or when a pop frees space in
// the same cycle. DEPTH must be a power of two so the pointers wrap naturally.
module conv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int POP_N = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             ready_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] POP_CNT  = (PTR_W+1)'(POP_N);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, w_pop_amt;
  logic             w_full, w_do_push, w_do_pop;

  assign w_full    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~w_full | w_do_pop);
  assign w_pop_amt = (count_q < POP_CNT) ? count_q : POP_CNT;
  assign ready_o   = ~w_full | pop_i;
  assign data_o    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + w_pop_amt[PTR_W-1:0];
      count_q <= count_q + (PTR_W+1)'(w_do_push) - (w_do_pop ? w_pop_amt : '0);
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module conv_top_module #(
  parameter int IF_CELL_SIZE        = 10,
  parameter int IF_ADDRESS_SIZE     = 8,
  parameter int FILTER_CELL_SIZE    = 8,
  parameter int FILTER_ADDRESS_SIZE = 8,
  parameter int STRIDE_SIZE         = 2,
  parameter int CELL_NUMS_IF        = 8,
  parameter int CELL_NUMS_FILTER    = 8,
  parameter int PAR_WRITE           = 1,
  parameter int PAR_READ            = 1,
  parameter int DEPTH               = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  chip_en,
  input  logic                                  start,
  input  logic [2:0]                            filter_size,
  input  logic [2:0]                            if_size,
  input  logic [STRIDE_SIZE-1:0]                stride,
  input  logic [PAR_WRITE*FILTER_CELL_SIZE-1:0] filter_buff_input,
  input  logic [PAR_WRITE*IF_CELL_SIZE-1:0]     if_buff_input,
  input  logic                                  filter_buff_write_en,
  input  logic                                  if_buff_write_en,
  input  logic                                  read_buffer_result,
  output logic                                  Done,
  output logic [FILTER_CELL_SIZE+IF_CELL_SIZE-2:0] par_sum
);
  localparam int IF_DATA_W = IF_CELL_SIZE - 2;   // top two IF bits are row flags
  localparam int PROD_W    = IF_DATA_W + FILTER_CELL_SIZE;
  localparam int SUM_W     = FILTER_CELL_SIZE + IF_CELL_SIZE - 1;
  localparam int FA        = FILTER_ADDRESS_SIZE;
  localparam int IA        = IF_ADDRESS_SIZE;
  localparam logic [FA-1:0] F_ONE = FA'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_F  = 3'd1,
    S_LOAD_IF = 3'd2,
    S_COMPUTE = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             f_q, f_d, n_q, n_d;
  logic [STRIDE_SIZE-1:0] s_q, s_d;
  logic [FA-1:0]          idx_q, idx_d;    // load index, then MAC tap index
  logic [IA-1:0]          base_q, base_d;  // k*S of the output being built
  logic [SUM_W-1:0]       acc_q, acc_d, w_acc_next;

  logic [FILTER_CELL_SIZE-1:0] f_mem_q  [CELL_NUMS_FILTER];
  logic [IF_DATA_W-1:0]        if_mem_q [CELL_NUMS_IF];

  logic [PAR_WRITE*FILTER_CELL_SIZE-1:0] w_f_head;
  logic [PAR_WRITE*IF_CELL_SIZE-1:0]     w_if_head;
  logic [SUM_W-1:0]                      w_res_head;
  logic w_f_empty, w_if_empty, w_res_empty, w_res_ready;
  logic w_f_pop, w_if_pop, w_res_push, w_f_ready_unused, w_if_ready_unused;
  logic [1:0] w_unused_flags;

  logic [IA-1:0]               w_if_addr, w_next_end;
  logic [IF_DATA_W-1:0]        w_if_word;
  logic [FILTER_CELL_SIZE-1:0] w_w_word;
  logic [PROD_W-1:0]           w_prod;

  conv_fifo #(.WIDTH(PAR_WRITE*FILTER_CELL_SIZE), .DEPTH(DEPTH), .POP_N(1)) u_f_fifo (
    .clk(clk), .rst(rst), .push_i(filter_buff_write_en & chip_en), .pop_i(w_f_pop & chip_en),
    .data_i(filter_buff_input), .data_o(w_f_head), .empty_o(w_f_empty), .ready_o(w_f_ready_unused));

  conv_fifo #(.WIDTH(PAR_WRITE*IF_CELL_SIZE), .DEPTH(DEPTH), .POP_N(1)) u_if_fifo (
    .clk(clk), .rst(rst), .push_i(if_buff_write_en & chip_en), .pop_i(w_if_pop & chip_en),
    .data_i(if_buff_input), .data_o(w_if_head), .empty_o(w_if_empty), .ready_o(w_if_ready_unused));

  conv_fifo #(.WIDTH(SUM_W), .DEPTH(DEPTH), .POP_N(PAR_READ)) u_res_fifo (
    .clk(clk), .rst(rst), .push_i(w_res_push & chip_en), .pop_i(read_buffer_result & chip_en),
    .data_i(acc_q), .data_o(w_res_head), .empty_o(w_res_empty), .ready_o(w_res_ready));

  assign w_unused_flags = w_if_head[IF_CELL_SIZE-1:IF_CELL_SIZE-2];
  assign par_sum        = w_res_empty ? '0 : w_res_head;
  assign Done           = (state_q == S_DONE);

  // Scratchpad read muxes; out-of-range addresses read as zero.
  assign w_if_addr = base_q + IA'(idx_q);
  always_comb begin
    w_if_word = '0;
    w_w_word  = '0;
    for (int i = 0; i < CELL_NUMS_IF; i++)
      if (w_if_addr == IA'(i)) w_if_word = if_mem_q[i];
    for (int i = 0; i < CELL_NUMS_FILTER; i++)
      if (idx_q == FA'(i)) w_w_word = f_mem_q[i];
  end

  assign w_prod = PROD_W'(w_if_word) * PROD_W'(w_w_word);

`ifdef CONV_RESULT_SATURATE_EN
  // One extra carry bit is enough: each step adds less than 2^SUM_W.
  logic [SUM_W:0] w_sum_ext;
  assign w_sum_ext  = {1'b0, acc_q} + (SUM_W+1)'(w_prod);
  assign w_acc_next = w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
`else
  assign w_acc_next = acc_q + SUM_W'(w_prod);
`endif

  // End of the window after the one just written; past N means last output.
  assign w_next_end = base_q + IA'(s_q) + IA'(f_q);

  always_comb begin
    state_d    = state_q;
    f_d        = f_q;
    n_d        = n_q;
    s_d        = s_q;
    idx_d      = idx_q;
    base_d     = base_q;
    acc_d      = acc_q;
    w_f_pop    = 1'b0;
    w_if_pop   = 1'b0;
    w_res_push = 1'b0;
    case (state_q)
      // A start seen in DONE passes back through idle and launches the next
      // job in the same cycle, exactly as a start seen in IDLE.
      S_IDLE, S_DONE: begin
        if (start) begin
          f_d     = filter_size;
          n_d     = if_size;
          s_d     = (stride == '0) ? STRIDE_SIZE'(1) : stride;
          idx_d   = '0;
          state_d = S_LOAD_F;
        end
      end
      S_LOAD_F: begin
        if (f_q == 3'd0) begin
          state_d = S_LOAD_IF;
        end else if (!w_f_empty) begin
          w_f_pop = 1'b1;
          if (idx_q + F_ONE == FA'(f_q)) begin
            idx_d   = '0;
            state_d = S_LOAD_IF;
          end else begin
            idx_d = idx_q + F_ONE;
          end
        end
      end
      S_LOAD_IF: begin
        if (n_q != 3'd0 && !w_if_empty) w_if_pop = 1'b1;
        if (n_q == 3'd0 || (!w_if_empty && idx_q + F_ONE == FA'(n_q))) begin
          idx_d   = '0;
          base_d  = '0;
          acc_d   = '0;
          state_d = (f_q == 3'd0 || f_q > n_q) ? S_DONE : S_COMPUTE;
        end else if (w_if_pop) begin
          idx_d = idx_q + F_ONE;
        end
      end
      S_COMPUTE: begin
        acc_d = w_acc_next;
        if (idx_q + F_ONE == FA'(f_q)) state_d = S_WRITE;
        else                           idx_d   = idx_q + F_ONE;
      end
      S_WRITE: begin
        if (w_res_ready) begin
          w_res_push = 1'b1;
          acc_d      = '0;
          idx_d      = '0;
          base_d     = base_q + IA'(s_q);
          state_d    = (w_next_end > IA'(n_q)) ? S_DONE : S_COMPUTE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      for (int i = 0; i < CELL_NUMS_FILTER; i++) f_mem_q[i] <= '0;
      for (int i = 0; i < CELL_NUMS_IF; i++)     if_mem_q[i] <= '0;
    end else if (chip_en) begin
      state_q <= state_d;
      f_q     <= f_d;
      n_q     <= n_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      for (int i = 0; i < CELL_NUMS_FILTER; i++)
        if (w_f_pop && idx_q == FA'(i)) f_mem_q[i] <= w_f_head[FILTER_CELL_SIZE-1:0];
      for (int i = 0; i < CELL_NUMS_IF; i++)
        if (w_if_pop && idx_q == FA'(i)) if_mem_q[i] <= w_if_head[IF_DATA_W-1:0];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_conv_top_module.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_conv_top_module                                            |
// | Purpose  : Directed self-checking bench for conv_top_module with         |
// |            hand-computed expected convolution results.                   |
// | Options  : CONV_RESULT_SATURATE_EN selects the saturated expectation.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_conv_top_module;
  logic        clk = 1'b0;
  logic        rst, chip_en, start;
  logic [2:0]  filter_size, if_size;
  logic [1:0]  stride;
  logic [7:0]  filter_buff_input;
  logic [9:0]  if_buff_input;
  logic        filter_buff_write_en, if_buff_write_en, read_buffer_result;
  logic        Done;
  logic [16:0] par_sum;

  int checks   = 0;
  int failures = 0;

  conv_top_module dut (
    .clk(clk), .rst(rst), .chip_en(chip_en), .start(start),
    .filter_size(filter_size), .if_size(if_size), .stride(stride),
    .filter_buff_input(filter_buff_input), .if_buff_input(if_buff_input),
    .filter_buff_write_en(filter_buff_write_en), .if_buff_write_en(if_buff_write_en),
    .read_buffer_result(read_buffer_result), .Done(Done), .par_sum(par_sum));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_f(input logic [7:0] v);
    @(negedge clk);
    filter_buff_input = v;
    filter_buff_write_en = 1'b1;
    @(negedge clk);
    filter_buff_write_en = 1'b0;
  endtask

  task automatic push_if(input logic [9:0] v);
    @(negedge clk);
    if_buff_input = v;
    if_buff_write_en = 1'b1;
    @(negedge clk);
    if_buff_write_en = 1'b0;
  endtask

  // Returns at the negedge just after the start edge.
  task automatic run(input logic [2:0] f, input logic [2:0] n, input logic [1:0] s);
    @(negedge clk);
    filter_size = f;
    if_size     = n;
    stride      = s;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (Done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, Done}, 32'd1);
  endtask

  // Checks the current head, then pops it.
  task automatic pop_check(input string tag, input logic [16:0] exp);
    check(tag, {15'd0, par_sum}, {15'd0, exp});
    read_buffer_result = 1'b1;
    @(negedge clk);
    read_buffer_result = 1'b0;
  endtask

  initial begin
    rst = 1'b1; chip_en = 1'b1; start = 1'b0;
    filter_size = '0; if_size = '0; stride = '0;
    filter_buff_input = '0; if_buff_input = '0;
    filter_buff_write_en = 1'b0; if_buff_write_en = 1'b0; read_buffer_result = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_sum", {15'd0, par_sum}, 32'd0);

    // F=2, N=4, S=1; IF flag bits set and must not affect the arithmetic.
    repeat (2) push_f(8'd7);
    repeat (4) push_if({2'b11, 8'd15});
    run(3'd2, 3'd4, 2'd1);
    wait_done("a_done");
    pop_check("a_r0", 17'd210);
    pop_check("a_r1", 17'd210);
    pop_check("a_r2", 17'd210);
    check("a_empty", {15'd0, par_sum}, 32'd0);
    pop_check("a_pop_empty", 17'd0);
    check("a_still_empty", {15'd0, par_sum}, 32'd0);

    // F=3, N=6, S=2 with a chip_en hold in the middle of the second output.
    repeat (3) push_f(8'd1);
    for (int i = 1; i <= 6; i++) push_if(10'(i));
    run(3'd3, 3'd6, 2'd2);
    repeat (14) @(negedge clk);
    check("b_first_out", {15'd0, par_sum}, 32'd6);
    chip_en = 1'b0;
    read_buffer_result = 1'b1;
    filter_buff_input = 8'd77;
    filter_buff_write_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_hold_sum", {15'd0, par_sum}, 32'd6);
      check("b_hold_done", {31'd0, Done}, 32'd0);
    end
    chip_en = 1'b1;
    read_buffer_result = 1'b0;
    filter_buff_write_en = 1'b0;
    wait_done("b_done");
    pop_check("b_r0", 17'd6);
    pop_check("b_r1", 17'd12);
    check("b_empty", {15'd0, par_sum}, 32'd0);

    // Stride 0 behaves as stride 1: W=1,2 over IF=3,4,5 -> 11, 14.
    push_f(8'd1); push_f(8'd2);
    push_if(10'd3); push_if(10'd4); push_if(10'd5);
    run(3'd2, 3'd3, 2'd0);
    wait_done("c_done");
    pop_check("c_r0", 17'd11);
    pop_check("c_r1", 17'd14);
    check("c_empty", {15'd0, par_sum}, 32'd0);

    // F > N: loads then finishes with no results.
    repeat (4) push_f(8'd1);
    repeat (2) push_if(10'd1);
    run(3'd4, 3'd2, 2'd1);
    wait_done("d_done");
    check("d_no_result", {15'd0, par_sum}, 32'd0);

    // Full-scale 7-tap: 7*255*255 = 455175.
    repeat (7) push_f(8'd255);
    repeat (7) push_if(10'd255);
    run(3'd7, 3'd7, 2'd1);
    wait_done("e_done");
`ifdef CONV_RESULT_SATURATE_EN
    check("e_result", {15'd0, par_sum}, 32'd131071);
`else
    check("e_result", {15'd0, par_sum}, 32'd61959);
`endif

    // Reset mid-COMPUTE; the leftover word in each input FIFO and the
    // unpopped result must be discarded.
    repeat (8) push_f(8'd9);
    repeat (8) push_if(10'd9);
    run(3'd7, 3'd7, 2'd1);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("f_rst_done", {31'd0, Done}, 32'd0);
    check("f_rst_sum", {15'd0, par_sum}, 32'd0);
    push_f(8'd3);
    push_if(10'd4);
    run(3'd1, 3'd1, 2'd1);
    wait_done("f_done");
    pop_check("f_r0", 17'd12);
    check("f_empty", {15'd0, par_sum}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_top_module.md
CONV_TOP_MODULE -- requirements
Module: conv_top_module

Interface
REQ-001 Parameters (name, default, meaning):
- IF_CELL_SIZE, 10: IF word width; bits [IF_CELL_SIZE-1:IF_CELL_SIZE-2] are row flags, ignored by arithmetic; low IF_CELL_SIZE-2 bits are unsigned data.
- IF_ADDRESS_SIZE, 8: IF scratchpad address width.
- FILTER_CELL_SIZE, 8: unsigned filter word width.
- FILTER_ADDRESS_SIZE, 8: filter scratchpad address width.
- STRIDE_SIZE, 2: stride field width.
- CELL_NUMS_IF, 8: IF scratchpad entries.
- CELL_NUMS_FILTER, 8: filter scratchpad entries.
- PAR_WRITE, 1: words accepted per buffer write.
- PAR_READ, 1: results popped per read.
- DEPTH, 64: depth of each FIFO (IF, filter, result).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- chip_en, in, 1: global enable; when low, all state holds.
- start, in, 1: begin a job when sampled high in IDLE.
- filter_size, in, 3: filter length F.
- if_size, in, 3: input length N.
- stride, in, STRIDE_SIZE: step S.
- filter_buff_input, in, PAR_WRITE*FILTER_CELL_SIZE: filter write data.
- if_buff_input, in, PAR_WRITE*IF_CELL_SIZE: IF write data.
- filter_buff_write_en, in, 1: push filter FIFO.
- if_buff_write_en, in, 1: push IF FIFO.
- read_buffer_result, in, 1: pop result FIFO.
- Done, out, 1: job complete.
- par_sum, out, FILTER_CELL_SIZE+IF_CELL_SIZE-1 (17): result FIFO head.

Function
REQ-003 On a rising edge with chip_en=1, a write enable pushes its input into the matching FIFO if not full; writes to a full FIFO are dropped.
REQ-004 FSM states: IDLE, LOAD_F, LOAD_IF, COMPUTE, WRITE, DONE.
REQ-005 IDLE->LOAD_F on start=1; F, N, S are latched that cycle; S=0 is treated as 1.
REQ-006 LOAD_F pops one filter word per cycle into filter scratchpad entries 0..F-1, stalling while the filter FIFO is empty; then LOAD_IF.
REQ-007 LOAD_IF pops N IF words into IF scratchpad entries 0..N-1 likewise; then COMPUTE.
REQ-008 If F=0 or F>N, the FSM goes directly to DONE after loading; no results are produced.
REQ-009 Output count K = floor((N-F)/S)+1; output k = sum over j=0..F-1 of IF[k*S+j]*W[j], all unsigned.
REQ-010 COMPUTE performs one MAC per cycle (F cycles per output); WRITE pushes the sum into the result FIFO in 1 cycle, stalling while it is full.
REQ-011 The accumulator clears before each output; sums wrap modulo 2^17.
REQ-012 After the K-th write the FSM enters DONE, where Done=1 is held; the FSM returns to IDLE on the next start, which also begins a new job.
REQ-013 par_sum shows the result FIFO head (first-word fall-through), or 0 when empty; read_buffer_result with chip_en=1 pops PAR_READ entries; a pop when empty is ignored.
REQ-014 Simultaneous push and pop on the result FIFO are both performed.

Reset
REQ-015 With rst=1 at a clock edge: FSM to IDLE, all FIFOs empty, scratchpads and accumulator zeroed, Done=0, par_sum=0; reset overrides chip_en and aborts any job mid-operation.

Configuration
REQ-016 With macro CONV_RESULT_SATURATE_EN defined, the accumulator saturates at 2^17-1 instead of wrapping; without it, sums wrap per REQ-011.

Verification
REQ-017 Push 2 filter words of 7 and 4 IF words of 15; start with F=2, N=4, S=1 -> Done=1; three results of 210; three pops empty the FIFO and par_sum=0.
REQ-018 IF = 1,2,3,4,5,6; W = 1,1,1; F=3, N=6, S=2 -> results 6, 12.
REQ-019 F=4, N=2 -> Done=1 with no results; par_sum=0.
REQ-020 Hold chip_en=0 mid-COMPUTE for 5 cycles -> state and outputs unchanged; final results identical to an uninterrupted run.
REQ-021 Seven IF words and 7 filter words of 255, F=N=7 -> 455175 mod 2^17 = 61959 (131071 with CONV_RESULT_SATURATE_EN).
REQ-022 rst=1 during COMPUTE -> next cycle Done=0, par_sum=0, FIFOs empty.
